// File: rtl/cache_event_monitor.sv
// Cache access monitor: saturating per-way hit/miss counters, a ring trace buffer that a trigger can freeze, and a valid/ready drain port.
// Optional one-hot checking of way_hit (sticky err) is built when CACHE_MON_ONEHOT_CHK_EN is defined.
module cache_event_monitor #(
    parameter int WAYS  = 4,
    parameter int IDX_W = 8,
    parameter int CMD_W = 4,
    parameter int CNT_W = 32,
    parameter int DEPTH = 16,
    localparam int WAY_W = $clog2(WAYS),
    localparam int ENT_W = 1 + WAY_W + CMD_W + IDX_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mon_en,
    input  logic                  clr,
    input  logic                  ev_valid,
    input  logic [WAYS-1:0]       way_hit,
    input  logic [IDX_W-1:0]      index,
    input  logic [CMD_W-1:0]      bit_cmd,
    input  logic                  trig,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [ENT_W-1:0]      rd_data,
    output logic [WAYS*CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0]      miss_cnt,
    output logic                  frozen,
    output logic                  ovf,
    output logic                  err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_FROZEN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             capture;
    logic             is_hit;
    logic [WAY_W-1:0] low_way;
    logic [ENT_W-1:0] entry;

    // clr wins over capture, so gating here keeps every consumer of capture consistent.
    assign capture = rst_n && !clr && (state_q == S_CAPTURE) && ev_valid;
    assign is_hit  = |way_hit;
    assign frozen  = (state_q == S_FROZEN);

    always_comb begin
        low_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_hit[w]) begin
                low_way = WAY_W'(w);
            end
        end
    end

    assign entry = {is_hit, low_way, bit_cmd, index};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (mon_en) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (trig) begin
                    state_d = S_FROZEN;
                end else if (!mon_en) begin
                    state_d = S_IDLE;
                end
            end
            S_FROZEN: state_d = S_FROZEN;
            default:  state_d = S_IDLE;
        endcase
        if (clr) begin
            state_d = S_IDLE;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clr) begin
                    cnt_d = '0;
                end else if (capture && is_hit && (low_way == WAY_W'(gi)) && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign hit_cnt[gi*CNT_W +: CNT_W] = cnt_q;
        end
    endgenerate

    logic [CNT_W-1:0] miss_q, miss_d;

    always_comb begin
        miss_d = miss_q;
        if (clr) begin
            miss_d = '0;
        end else if (capture && !is_hit && (miss_q != '1)) begin
            miss_d = miss_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            miss_q <= '0;
        end else begin
            miss_q <= miss_d;
        end
    end

    assign miss_cnt = miss_q;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             pop, full;

    assign full = (count_q == OCC_W'(DEPTH));
    assign pop  = (count_q != '0) && rd_ready;

    // A write into a full buffer without a pop drops the oldest entry by advancing the read pointer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (capture) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (capture && !pop) begin
            if (full) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                ovf_d    = 1'b1;
            end else begin
                count_d = count_q + OCC_W'(1);
            end
        end else if (pop && !capture) begin
            count_d = count_q - OCC_W'(1);
        end
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

    assign rd_valid = (count_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign ovf      = ovf_q;

`ifdef CACHE_MON_ONEHOT_CHK_EN
    logic err_q, err_d;
    logic multi_hot;

    assign multi_hot = |(way_hit & (way_hit - WAYS'(1)));

    always_comb begin
        err_d = err_q;
        if (clr) begin
            err_d = 1'b0;
        end else if (capture && multi_hot) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cache_event_monitor.sv
// Directed bench for cache_event_monitor: counters, ring overwrite, concurrent push/pop, trigger freeze,
// multi-hot flagging, saturation, clr and reset.
module tb_cache_event_monitor;

    localparam int WAYS  = 4;
    localparam int IDX_W = 8;
    localparam int CMD_W = 4;
    localparam int CNT_W = 8;
    localparam int DEPTH = 16;
    localparam int ENT_W = 1 + 2 + CMD_W + IDX_W;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  mon_en = 1'b0;
    logic                  clr = 1'b0;
    logic                  ev_valid = 1'b0;
    logic [WAYS-1:0]       way_hit = '0;
    logic [IDX_W-1:0]      index = '0;
    logic [CMD_W-1:0]      bit_cmd = '0;
    logic                  trig = 1'b0;
    logic                  rd_valid;
    logic                  rd_ready = 1'b0;
    logic [ENT_W-1:0]      rd_data;
    logic [WAYS*CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0]      miss_cnt;
    logic                  frozen;
    logic                  ovf;
    logic                  err;

    int n_checks = 0;
    int n_fail   = 0;

    cache_event_monitor #(
        .WAYS(WAYS), .IDX_W(IDX_W), .CMD_W(CMD_W), .CNT_W(CNT_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mon_en(mon_en), .clr(clr), .ev_valid(ev_valid),
        .way_hit(way_hit), .index(index), .bit_cmd(bit_cmd), .trig(trig),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .frozen(frozen), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] hc(input int w);
        return hit_cnt[w*CNT_W +: CNT_W];
    endfunction

    function automatic logic [ENT_W-1:0] ent(input logic h, input logic [1:0] w,
                                              input logic [3:0] c, input logic [7:0] i);
        return {h, w, c, i};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] wh, input logic [3:0] cmd, input logic [7:0] idx);
        ev_valid = 1'b1;
        way_hit  = wh;
        bit_cmd  = cmd;
        index    = idx;
        tick();
        ev_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [ENT_W-1:0] exp);
        check({tag, ".valid"}, rd_valid, 1);
        check({tag, ".data"}, rd_data, exp);
        $display("pop %s data=%h", tag, rd_data);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic clear_and_arm();
        clr    = 1'b1;
        mon_en = 1'b1;
        tick();
        clr = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        tick();
        tick();
        check("rst.rd_valid", rd_valid, 0);
        check("rst.miss", miss_cnt, 0);
        check("rst.hit", hit_cnt, 0);
        check("rst.frozen", frozen, 0);
        check("rst.ovf", ovf, 0);
        check("rst.err", err, 0);
        rst_n = 1'b1;
        tick();

        // Basic hits and one miss
        mon_en = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) send(4'b0010, 4'(i + 1), 8'(8'h10 + i));
        send(4'b0000, 4'hA, 8'h55);
        check("basic.hit1", hc(1), 3);
        check("basic.hit0", hc(0), 0);
        check("basic.miss", miss_cnt, 1);
        for (int i = 0; i < 3; i++) pop_expect($sformatf("basic.e%0d", i), ent(1, 2'd1, 4'(i + 1), 8'(8'h10 + i)));
        pop_expect("basic.miss_entry", ent(0, 2'd0, 4'hA, 8'h55));
        check("basic.empty", rd_valid, 0);

        // Overwrite: 20 events, no reads
        clear_and_arm();
        for (int e = 1; e <= 20; e++) begin
            send(4'(1 << (e % 4)), 4'(e), 8'(e));
            if (e == 16) check("ovf.not_yet", ovf, 0);
        end
        check("ovf.set", ovf, 1);
        for (int e = 5; e <= 20; e++) pop_expect($sformatf("ovf.e%0d", e), ent(1, 2'(e % 4), 4'(e), 8'(e)));
        check("ovf.empty", rd_valid, 0);

        // Full buffer with simultaneous push and pop
        clear_and_arm();
        for (int e = 1; e <= 16; e++) send(4'b0001, 4'(e), 8'(e));
        for (int e = 17; e <= 20; e++) begin
            check($sformatf("pp.head%0d", e - 16), rd_data, ent(1, 2'd0, 4'(e - 16), 8'(e - 16)));
            rd_ready = 1'b1;
            send(4'b0001, 4'(e), 8'(e));
            rd_ready = 1'b0;
        end
        check("pp.ovf", ovf, 0);
        for (int e = 5; e <= 20; e++) pop_expect($sformatf("pp.e%0d", e), ent(1, 2'd0, 4'(e), 8'(e)));
        check("pp.empty", rd_valid, 0);

        // Trigger on event 7 of 10
        clear_and_arm();
        for (int e = 1; e <= 10; e++) begin
            trig = (e == 7);
            send(4'b0100, 4'(e), 8'(e));
            trig = 1'b0;
            if (e == 6) check("trig.pre", frozen, 0);
            if (e == 7) check("trig.frozen", frozen, 1);
        end
        check("trig.hit2", hc(2), 7);
        check("trig.miss", miss_cnt, 0);
        mon_en = 1'b0;
        tick();
        check("trig.hold", frozen, 1);
        for (int e = 1; e <= 7; e++) pop_expect($sformatf("trig.e%0d", e), ent(1, 2'd2, 4'(e), 8'(e)));
        check("trig.empty", rd_valid, 0);

        // Multi-hot, then CAPTURE -> IDLE on mon_en low
        clear_and_arm();
        send(4'b0110, 4'h3, 8'h77);
`ifdef CACHE_MON_ONEHOT_CHK_EN
        check("mh.err", err, 1);
`else
        check("mh.err", err, 0);
`endif
        check("mh.hit1", hc(1), 1);
        check("mh.hit2", hc(2), 0);
        mon_en = 1'b0;
        send(4'b0000, 4'h1, 8'h01);
        send(4'b0000, 4'h2, 8'h02);
        check("idle.miss", miss_cnt, 1);
        pop_expect("mh.entry", ent(1, 2'd1, 4'h3, 8'h77));
        pop_expect("idle.entry", ent(0, 2'd0, 4'h1, 8'h01));
        check("idle.empty", rd_valid, 0);

        // Saturation, then freeze, then clr with concurrent capture and pop
        clear_and_arm();
        for (int i = 0; i < 256; i++) send(4'b0001, 4'h0, 8'(i));
        check("sat.hit0", hc(0), 8'hFF);
        trig = 1'b1;
        send(4'b0001, 4'h0, 8'h00);
        trig = 1'b0;
        check("sat.frozen", frozen, 1);
        clr      = 1'b1;
        mon_en   = 1'b0;
        rd_ready = 1'b1;
        send(4'b0001, 4'h0, 8'h00);
        clr      = 1'b0;
        rd_ready = 1'b0;
        check("clr.hit", hit_cnt, 0);
        check("clr.rd_valid", rd_valid, 0);
        check("clr.ovf", ovf, 0);
        check("clr.frozen", frozen, 0);
        check("clr.err", err, 0);
        send(4'b0000, 4'h0, 8'h00);
        check("clr.idle_miss", miss_cnt, 0);
        check("clr.idle_valid", rd_valid, 0);

        // Reset mid-drain
        mon_en = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) send(4'b1000, 4'(i), 8'(i));
        pop_expect("rst.first", ent(1, 2'd3, 4'h0, 8'h00));
        rst_n = 1'b0;
        mon_en = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rstmid.valid", rd_valid, 0);
        check("rstmid.hit3", hc(3), 0);
        tick();
        check("rstmid.still", rd_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_event_monitor.md
# cache_event_monitor

Parametrised cache-access monitor for the cache simulation and bring-up environment. It sits beside the cache controller and samples each completed access: the one-hot way-hit vector, the set index and the bit-array command. It keeps saturating per-way hit and miss counters, flags illegal multi-way hits, and records events in a ring trace buffer. The buffer can be frozen by a trigger and drained through a valid/ready port, replacing per-net probe decoding with a reusable, width-generic block.

## Interface
- WAYS, 4: associativity; width of the way-hit vector, power of 2, ≥2.
- IDX_W, 8: set-index width.
- CMD_W, 4: bit-command width.
- CNT_W, 32: width of each event counter.
- DEPTH, 16: trace entries, power of 2, ≥2.
- Derived: WAY_W = clog2(WAYS); ENT_W = 1 + WAY_W + CMD_W + IDX_W.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- mon_en  in  1  capture enable.
- clr  in  1  synchronous clear of counters, buffer, flags and state (not a reset).
- ev_valid  in  1  an access completes this cycle.
- way_hit  in  WAYS  one-hot hit vector; all-zero means miss.
- index  in  IDX_W  set index of the access.
- bit_cmd  in  CMD_W  bit-array command issued with the access.
- trig  in  1  freeze request.
- rd_valid  out  1  trace entry available.
- rd_ready  in  1  consumer accepts entry.
- rd_data  out  ENT_W  {hit, way, bit_cmd, index}, oldest first.
- hit_cnt  out  WAYS*CNT_W  per-way hit counters; way w at [w*CNT_W +: CNT_W].
- miss_cnt  out  CNT_W  miss counter.
- frozen  out  1  capture stopped by trigger.
- ovf  out  1  sticky: an unread entry was overwritten.
- err  out  1  sticky: multi-hot way_hit seen.

## Operation
- States: IDLE, CAPTURE, FROZEN.
  - IDLE → CAPTURE when mon_en = 1.
  - CAPTURE → IDLE when mon_en = 0.
  - CAPTURE → FROZEN when trig = 1. The event in the trig cycle is still captured.
  - FROZEN is left only by clr or reset, which return to IDLE. mon_en is ignored in FROZEN.
- Capture occurs when state is CAPTURE and ev_valid = 1.
  - Hit (way_hit ≠ 0): the entry has hit = 1 and way = index of the lowest set bit. hit_cnt[way] increments.
  - Miss: the entry has hit = 0 and way = 0. miss_cnt increments.
- Counters saturate at all-ones and never wrap.
- Ring buffer uses write pointer, read pointer and occupancy count (0..DEPTH). Pointers wrap modulo DEPTH.
- rd_valid = (count ≠ 0). rd_data is the entry at the read pointer. An entry pops when rd_valid && rd_ready.
- Write to a full buffer, no pop: the oldest entry is dropped (read pointer advances), count stays DEPTH, ovf sets.
- Write and pop in the same cycle: both take effect, count is unchanged, and ovf does not set, even when full.
- Pop on an empty buffer: ignored.
- Draining is allowed in every state. In FROZEN no writes occur, so the buffer holds the DEPTH most recent events up to and including the trig cycle.
- clr has priority over capture and pop in the same cycle.
- Reset and clr values: state IDLE, all counters 0, count 0, pointers 0, rd_valid 0, frozen 0, ovf 0, err 0. rd_data is don't-care while rd_valid = 0.

## Timing
- An event sampled at edge N updates counters, count and rd_valid so they are visible after edge N.
- An event into an empty buffer presents rd_valid = 1 with that entry in the cycle after its ev_valid cycle.
- rd_data is combinational from storage at the read pointer. A pop at edge N presents the next entry after N.
- frozen rises the cycle after trig is sampled in CAPTURE.
- Reset mid-drain discards all entries.
- Throughput: one capture and one pop per cycle.

## Configuration
- CACHE_MON_ONEHOT_CHK_EN defined:
  - err sets on any captured event with more than one way_hit bit set.
  - That event still counts as a hit on the lowest set way.
- Undefined:
  - err is tied to 0 and the popcount logic is not built.
  - Multi-hot events are handled as lowest-way hits with no flag.

## Test plan
- Reset, then mon_en = 1 and 3 events with way_hit = 4'b0010 and 1 event with 4'b0000 → hit_cnt[1] = 3, miss_cnt = 1, rd_valid = 1, first entry {1, 1, cmd, idx}.
- 20 events with DEPTH = 16, no reads → count = 16, ovf = 1, drain yields events 5..20 in order, then rd_valid = 0.
- With the buffer full, ev_valid and rd_ready together for 4 cycles → count stays 16, ovf stays 0, oldest 4 entries popped in order.
- trig on event 7 of 10 → frozen = 1 on the next cycle, exactly 7 entries stored, events 8..10 counted nowhere.
- Macro on: way_hit = 4'b0110 → err = 1, hit_cnt[1] += 1. Macro off: the same stimulus gives err = 0.
- Preset hit_cnt[0] to all-ones, then one more way-0 hit → counter holds all-ones. Assert clr → all counters 0, state IDLE, rd_valid = 0.
